sim_term_ctrl: RTL

//  Simulation-termination controller for the Verilator top. Snoops the main-RAM write port for a store to
//  the end-of-sim mailbox word and captures the written status code. It then drains a fixed number of

---
 rtl/sim_term_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sim_term_ctrl.sv
// sim_term_ctrl: simulation-termination controller.
//   Watches the main-RAM write port for a store to the end-of-sim mailbox word.
//   It captures the status code, waits DrainCycles so in-flight traffic can flush,
//   and then raises a sticky finish request. An optional cycle watchdog ends the
//   run with a timeout flag when no mailbox store arrives.
//
// Ports:
//   clk_i        single clock, posedge
//   rst_i        asynchronous reset, active-high
//   mem_req_i    RAM request strobe
//   mem_we_i     RAM write enable
//   mem_addr_i   RAM word address, offset from MemBase
//   mem_wdata_i  RAM write data
//   mem_rst_ni   RAM-local reset, active-low; snoop ignored while low
//   finish_o     sticky: simulation may terminate
//   pass_o       valid with finish_o: code == 0 and no timeout
//   timeout_o    valid with finish_o: watchdog expired
//   code_o       captured mailbox data, 0 on timeout
//   cycles_o     cycles spent in RUN, saturating
module sim_term_ctrl #(
  parameter logic [31:0] MemBase       = 32'h1000_0000,
  parameter int unsigned AddrW         = 14,
  parameter logic [31:0] EndSimAddr    = 32'h1000_8000,
  parameter int unsigned DrainCycles   = 16,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned CntW          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [AddrW-1:0] mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  input  logic             mem_rst_ni,
  output logic             finish_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [31:0]      code_o,
  output logic [CntW-1:0]  cycles_o
);

  localparam int unsigned DataW       = 32;
  localparam int unsigned DrainW      = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam int unsigned DrainLast   = (DrainCycles == 0) ? 0 : DrainCycles - 1;
  localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam bit          WatchdogEn  = (TimeoutCycles != 0);
  localparam bit          SkipDrain   = (DrainCycles == 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CntW-1:0]     cycles_q, cycles_d;
  logic [DataW-1:0]    code_q, code_d;
  logic                timeout_q, timeout_d;
  logic                finish_q, finish_d;
  logic                pass_q, pass_d;

  // Mailbox decode: the byte address is formed 32 bits wide and wraps like the bus does.
  logic [DataW-1:0]    byte_off_c;
  logic [DataW-1:0]    byte_addr_c;
  logic                hit_c;

  assign byte_off_c  = DataW'({mem_addr_i, 2'b00});
  assign byte_addr_c = MemBase + byte_off_c;
  assign hit_c       = mem_req_i & mem_we_i & mem_rst_ni & (byte_addr_c == EndSimAddr);

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      cycles_q    <= '0;
      code_q      <= '0;
      timeout_q   <= 1'b0;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycles_q    <= cycles_d;
      code_q      <= code_d;
      timeout_q   <= timeout_d;
      finish_q    <= finish_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    cycles_d    = cycles_q;
    code_d      = code_q;
    timeout_d   = timeout_q;
    finish_d    = 1'b0;
    pass_d      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (cycles_q != {CntW{1'b1}}) begin
          cycles_d = cycles_q + CntW'(1);
        end
        // A mailbox store wins over a watchdog expiry in the same cycle.
        if (hit_c) begin
          code_d      = mem_wdata_i;
          drain_cnt_d = '0;
          state_d     = SkipDrain ? ST_DONE : ST_DRAIN;
        end else if (WatchdogEn && (cycles_q == CntW'(TimeoutLast))) begin
          code_d    = '0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DRAIN: begin
        // Later mailbox stores are ignored; the first code is kept.
        drain_cnt_d = drain_cnt_q + DrainW'(1);
        if (drain_cnt_q == DrainW'(DrainLast)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Status flags are derived from the next-state values so they register together.
    finish_d = (state_d == ST_DONE);
    pass_d   = finish_d & ~timeout_d & (code_d == '0);
  end

  assign finish_o  = finish_q;
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;
  assign code_o    = code_q;
  assign cycles_o  = cycles_q;

endmodule
